// File: rtl/vlsu_mask_sched.sv
// Mask-stream scheduler: hands the shared lane mask stream to the load or store
// unit, one instruction at a time, in the order the instructions were dispatched.
module vlsu_mask_sched #(
  parameter int unsigned NrLanes = 4,
  parameter int unsigned MaskW   = 16,
  parameter int unsigned Depth   = 4,
  parameter int unsigned BeatW   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         op_valid_i,
  output logic                         op_ready_o,
  input  logic                         op_is_load_i,
  input  logic                         op_masked_i,
  input  logic [BeatW-1:0]             op_nbeats_i,
  input  logic [NrLanes-1:0]           mask_valid_i,
  input  logic [NrLanes*MaskW-1:0]     mask_bits_i,
  output logic [NrLanes-1:0]           mask_ready_o,
  output logic                         ld_mask_valid_o,
  input  logic                         ld_mask_ready_i,
  output logic                         st_mask_valid_o,
  input  logic                         st_mask_ready_i,
  output logic [NrLanes*MaskW-1:0]     mask_bits_o,
  output logic [$clog2(Depth+1)-1:0]   pending_o,
  output logic                         busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth+1);
  localparam logic [PtrW:0] OccOne = 1;

  typedef enum logic {IDLE, STREAM} state_e;

  logic [PtrW:0]      r_wrPtr;
  logic [PtrW:0]      r_rdPtr;
  logic [Depth-1:0]   r_isLoad;
  logic [BeatW-1:0]   r_nbeats [Depth];
  state_e             r_state;
  logic [BeatW-1:0]   r_cnt;

  logic [PtrW-1:0]    w_wrIdx;
  logic [PtrW-1:0]    w_rdIdx;
  logic [PtrW-1:0]    w_nextIdx;
  logic [PtrW:0]      w_occ;
  logic               w_full;
  logic               w_needEntry;
  logic               w_push;
  logic               w_allValid;
  logic               w_headLoad;
  logic               w_grant;
  logic               w_lastBeat;

  assign w_wrIdx     = r_wrPtr[PtrW-1:0];
  assign w_rdIdx     = r_rdPtr[PtrW-1:0];
  assign w_nextIdx   = w_rdIdx + 1'b1;
  assign w_occ       = r_wrPtr - r_rdPtr;
  assign w_full      = (w_wrIdx == w_rdIdx) && (r_wrPtr[PtrW] != r_rdPtr[PtrW]);

  // Unmasked or zero-beat instructions never occupy a slot, so they are always taken.
  assign w_needEntry = op_masked_i && (op_nbeats_i != '0);
  assign op_ready_o  = !w_needEntry || !w_full;
  assign w_push      = op_valid_i && op_ready_o && w_needEntry;

  assign w_allValid      = &mask_valid_i;
  assign w_headLoad      = r_isLoad[w_rdIdx];
  assign ld_mask_valid_o = (r_state == STREAM) && w_headLoad && w_allValid;
  assign st_mask_valid_o = (r_state == STREAM) && !w_headLoad && w_allValid;
  assign w_grant         = (ld_mask_valid_o && ld_mask_ready_i) ||
                           (st_mask_valid_o && st_mask_ready_i);
  assign w_lastBeat      = w_grant && (r_cnt == BeatW'(1));
  assign mask_ready_o    = {NrLanes{w_grant}};
  assign mask_bits_o     = mask_bits_i;

  assign pending_o = CntW'(w_occ);
  assign busy_o    = (w_occ != '0);

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_isLoad[w_wrIdx] <= op_is_load_i;
      r_nbeats[w_wrIdx] <= op_nbeats_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_lastBeat) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
    end
  end

  // On the last beat the next head may be an older entry or the one being pushed
  // right now; either way cnt reloads on the same edge so no bubble appears.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_state <= STREAM;
            r_cnt   <= op_nbeats_i;
          end
        end
        STREAM: begin
          if (w_grant) begin
            if (r_cnt == BeatW'(1)) begin
              if ((w_occ != '0) && (w_occ != OccOne)) begin
                r_cnt <= r_nbeats[w_nextIdx];
              end else if (w_push) begin
                r_cnt <= op_nbeats_i;
              end else begin
                r_state <= IDLE;
                r_cnt   <= '0;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vlsu_mask_sched.sv
// Randomized and directed bench for vlsu_mask_sched; expected beats live in a
// scoreboard of per-beat owner records built from accepted instructions.
module tb_vlsu_mask_sched;

  localparam int NrLanes = 4;
  localparam int MaskW   = 16;
  localparam int Depth   = 4;
  localparam int BeatW   = 8;

  typedef struct packed {
    logic isLoad;
    logic last;
  } beat_t;

  logic                       clk;
  logic                       rst_ni;
  logic                       opValid;
  logic                       opReady;
  logic                       opIsLoad;
  logic                       opMasked;
  logic [BeatW-1:0]           opNbeats;
  logic [NrLanes-1:0]         maskValid;
  logic [NrLanes*MaskW-1:0]   maskBitsIn;
  logic [NrLanes-1:0]         maskReady;
  logic                       ldValid;
  logic                       ldReady;
  logic                       stValid;
  logic                       stReady;
  logic [NrLanes*MaskW-1:0]   maskBitsOut;
  logic [$clog2(Depth+1)-1:0] pending;
  logic                       busy;

  beat_t expBeats[$];
  int    pendCnt;
  int    testsRun;
  int    testsFailed;
  bit    acceptNow;

  vlsu_mask_sched #(
    .NrLanes(NrLanes), .MaskW(MaskW), .Depth(Depth), .BeatW(BeatW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .op_valid_i     (opValid),
    .op_ready_o     (opReady),
    .op_is_load_i   (opIsLoad),
    .op_masked_i    (opMasked),
    .op_nbeats_i    (opNbeats),
    .mask_valid_i   (maskValid),
    .mask_bits_i    (maskBitsIn),
    .mask_ready_o   (maskReady),
    .ld_mask_valid_o(ldValid),
    .ld_mask_ready_i(ldReady),
    .st_mask_valid_o(stValid),
    .st_mask_ready_i(stReady),
    .mask_bits_o    (maskBitsOut),
    .pending_o      (pending),
    .busy_o         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: compares the DUT against the scoreboard head, then retires granted beats.
  always @(negedge clk) begin : monitor
    bit    allV, expLd, expSt, expGrant, needEntry, expReady;
    beat_t head;
    acceptNow = 1'b0;
    if (rst_ni) begin
      allV = &maskValid;
      head = '0;
      if (expBeats.size() > 0) head = expBeats[0];
      expLd = (expBeats.size() > 0) && head.isLoad && allV;
      expSt = (expBeats.size() > 0) && !head.isLoad && allV;
      expGrant = (expLd && ldReady) || (expSt && stReady);
      needEntry = opMasked && (opNbeats != 0);
      expReady = !needEntry || (pendCnt < Depth);
      checkOutput("ld_valid", 64'(ldValid), 64'(expLd));
      checkOutput("st_valid", 64'(stValid), 64'(expSt));
      checkOutput("mask_ready", 64'(maskReady), 64'({NrLanes{expGrant}}));
      checkOutput("mask_bits", maskBitsOut, maskBitsIn);
      checkOutput("pending", 64'(pending), 64'(pendCnt));
      checkOutput("busy", 64'(busy), 64'(pendCnt != 0));
      checkOutput("op_ready", 64'(opReady), 64'(expReady));
      acceptNow = opValid && expReady && needEntry;
      if (expGrant) begin
        if (expBeats[0].last) pendCnt--;
        void'(expBeats.pop_front());
      end
    end
  end

  task automatic applyStimulus(input bit v, input bit isLoad, input bit masked,
                               input logic [BeatW-1:0] nb, input logic [NrLanes-1:0] lanes,
                               input bit ldr, input bit str);
    @(posedge clk);
    #1;
    opValid    = v;
    opIsLoad   = isLoad;
    opMasked   = masked;
    opNbeats   = nb;
    maskValid  = lanes;
    maskBitsIn = {$urandom, $urandom};
    ldReady    = ldr;
    stReady    = str;
    @(negedge clk);
    #2;
    if (rst_ni && acceptNow) begin
      for (int i = 0; i < int'(nb); i++) expBeats.push_back('{isLoad: isLoad, last: (i == int'(nb) - 1)});
      pendCnt++;
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_op_ready", 64'(opReady), 64'(1));
    checkOutput("rst_mask_ready", 64'(maskReady), 64'(0));
    checkOutput("rst_ld_valid", 64'(ldValid), 64'(0));
    checkOutput("rst_st_valid", 64'(stValid), 64'(0));
    checkOutput("rst_pending", 64'(pending), 64'(0));
    checkOutput("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (pendCnt != 0 && guard < 300) begin
      applyStimulus(0, 0, 0, 0, '1, 1, 1);
      guard++;
    end
    checkOutput("drain_done", 64'(pendCnt), 64'(0));
  endtask

  initial begin
    logic [NrLanes-1:0] lanes;
    testsRun    = 0;
    testsFailed = 0;
    pendCnt     = 0;
    rst_ni      = 1'b0;
    opValid     = 1'b0;
    opIsLoad    = 1'b0;
    opMasked    = 1'b0;
    opNbeats    = '0;
    maskValid   = '0;
    maskBitsIn  = '0;
    ldReady     = 1'b0;
    stReady     = 1'b0;
    #1;
    checkResetValues();
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;

    // Single 3-beat load
    applyStimulus(1, 1, 1, 3, '1, 1, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, '1, 1, 0);

    // Ordering: store(2), load(1), store(1)
    applyStimulus(1, 0, 1, 2, '0, 1, 1);
    applyStimulus(1, 1, 1, 1, '0, 1, 1);
    applyStimulus(1, 0, 1, 1, '0, 1, 1);
    repeat (6) applyStimulus(0, 0, 0, 0, '1, 1, 1);

    // Lane skew: lane 2 arrives two cycles late
    applyStimulus(1, 1, 1, 1, 4'b1011, 1, 1);
    applyStimulus(0, 0, 0, 0, 4'b1011, 1, 1);
    applyStimulus(0, 0, 0, 0, 4'b1111, 1, 1);
    applyStimulus(0, 0, 0, 0, 4'b1111, 1, 1);

    // Fill the FIFO with sinks stalled, then probe full and the discard cases
    for (int i = 0; i < Depth; i++) applyStimulus(1, i[0], 1, 2, '1, 0, 0);
    applyStimulus(1, 1, 1, 3, '1, 0, 0);
    applyStimulus(1, 1, 0, 3, '1, 0, 0);
    applyStimulus(1, 0, 1, 0, '1, 0, 0);
    checkOutput("full_pending", 64'(pending), 64'(Depth));
    drain();

    // Back-pressure mid-instruction
    applyStimulus(1, 1, 1, 4, '1, 1, 0);
    applyStimulus(0, 0, 0, 0, '1, 1, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, '1, 0, 0);
    drain();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      for (int l = 0; l < NrLanes; l++) lanes[l] = ($urandom_range(0, 9) < 8);
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 9) < 8),
                    BeatW'($urandom_range(0, 5)), lanes,
                    ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
    end
    drain();

    // Reset after the first of four beats
    applyStimulus(1, 1, 1, 4, '1, 1, 0);
    applyStimulus(0, 0, 0, 0, '1, 1, 0);
    @(posedge clk);
    #3;
    rst_ni = 1'b0;
    #1;
    checkResetValues();
    expBeats.delete();
    pendCnt = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_ni = 1'b1;
    #1;
    checkOutput("post_rst_busy", 64'(busy), 64'(0));
    applyStimulus(1, 0, 1, 2, '1, 0, 1);
    repeat (4) applyStimulus(0, 0, 0, 0, '1, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/vlsu_mask_sched.md
# vlsu_mask_sched

Mask-stream scheduler for the vector load/store unit. It shares the single per-lane mask interface between the load unit and the store unit, granting it strictly in instruction-dispatch order. Each masked instruction is recorded at meta-dispatch time with its load/store type and mask-beat count. The block then routes exactly that many lane-aligned mask beats to the owning unit before moving to the next instruction. It sits between the lanes' mask outputs and the load/store units' mask inputs, beside the control machine.

## Interface
- NrLanes, 4, number of lanes
- MaskW, 16, mask bits per lane per beat (DLEN/4)
- Depth, 4, order-FIFO entries (power of two, ≥2)
- BeatW, 8, width of the mask-beat count
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- op_valid_i  in  1  instruction dispatched by the control machine
- op_ready_o  out  1  instruction accepted
- op_is_load_i  in  1  1 = load, 0 = store
- op_masked_i  in  1  1 = instruction uses the mask (vm = 0)
- op_nbeats_i  in  BeatW  mask beats the instruction consumes
- mask_valid_i  in  NrLanes  per-lane mask beat valid
- mask_bits_i  in  NrLanes×MaskW  per-lane mask bits
- mask_ready_o  out  NrLanes  per-lane mask beat consumed
- ld_mask_valid_o  out  1  mask beat valid to the load unit
- ld_mask_ready_i  in  1  load unit accepts the beat
- st_mask_valid_o  out  1  mask beat valid to the store unit
- st_mask_ready_i  in  1  store unit accepts the beat
- mask_bits_o  out  NrLanes×MaskW  mask beat data, shared by both sinks
- pending_o  out  $clog2(Depth+1)  number of queued masked instructions
- busy_o  out  1  an instruction is queued or streaming

## Operation
**Accept**
- An instruction is accepted on op_valid_i && op_ready_o.
- If op_masked_i = 0 or op_nbeats_i = 0, it is accepted and discarded. No entry is written and op_ready_o = 1 regardless of occupancy.
- Otherwise the pair {is_load, nbeats} is written at the write pointer. op_ready_o = !full.
- Pointers are $clog2(Depth) bits, wrap modulo Depth, and carry an extra wrap bit for the full/empty distinction.

**Head and state**
- The head entry owns the mask stream.
- Beat counter cnt (BeatW) is loaded with head.nbeats when the head becomes valid.
- FSM states:
  - IDLE: FIFO empty. Goes to STREAM when an entry becomes visible.
  - STREAM: head valid. Each granted beat decrements cnt. On the grant where cnt = 1 the head is popped. If the FIFO is then non-empty, cnt reloads from the new head in the same edge and the state stays STREAM; otherwise the state goes to IDLE.

**Beat grant (join)**
- all_v = &mask_valid_i.
- ld_mask_valid_o = STREAM && head.is_load && all_v.
- st_mask_valid_o = STREAM && !head.is_load && all_v.
- The non-owning sink valid is always 0.
- grant = (ld_mask_valid_o && ld_mask_ready_i) || (st_mask_valid_o && st_mask_ready_i).
- mask_ready_o = {NrLanes{grant}}. Lanes are never consumed partially.
- mask_bits_o = mask_bits_i, passed through combinationally.

**Other rules**
- Simultaneous accept and pop: both take effect. Accept eligibility uses the pre-pop full flag, so no enqueue into a slot freed in the same cycle.
- pending_o = occupancy. busy_o = (pending_o != 0).
- Reset mid-stream: the FIFO, cnt and FSM clear immediately. In-flight beats are abandoned and no mask_ready_o pulses are issued.

## Timing
- Reset values:
  - op_ready_o = 1
  - mask_ready_o = 0
  - ld_mask_valid_o = 0 and st_mask_valid_o = 0
  - pending_o = 0 and busy_o = 0
  - FSM = IDLE, cnt = 0
- Accept-to-first-grant latency is 1 cycle: an entry written at edge N is head at N+1, so a beat can transfer in cycle N+1.
- Back-to-back instructions need no bubble. The first beat of the next instruction can be granted in the cycle after the last beat of the previous one.
- The mask path (valid/bits to sink, ready to lanes) is combinational. Sink readies may depend on valid; lane valids must not depend on mask_ready_o.
- Sustained throughput is 1 beat per cycle when all lanes are valid and the owning sink is ready.

## Test plan
- **Single load, 3 beats:** reset, then accept {load, masked, 3}; hold all lanes valid and ld ready = 1. Required: ld_mask_valid_o high for exactly 3 cycles starting 1 cycle after accept; st_mask_valid_o stays 0; mask_ready_o = all-ones on each of those cycles; busy_o falls after the 3rd beat.
- **Ordering:** enqueue store(2), load(1), store(1); tie both sink readies high. Required: beats go to st, st, ld, st, with no idle cycle between instructions; pending_o counts 3→2→1→0.
- **Lane skew:** queue one load; drive lane 2 valid 2 cycles after the other lanes. Required: no grant and mask_ready_o = 0 until all lanes are valid; the beat then transfers with mask_bits_o equal to the concatenated lane inputs.
- **Full FIFO and unmasked ops:** enqueue Depth = 4 masked ops with sinks stalled. Required: op_ready_o = 0 for a further masked op. An op with op_masked_i = 0, and an op with op_nbeats_i = 0, are each accepted in the same state and pending_o stays 4.
- **Back-pressure:** hold ld_mask_ready_i = 0 for 5 cycles mid-instruction. Required: cnt is unchanged, mask_ready_o = 0 and no lane beat is lost; the remaining beats complete once ready returns.
- **Reset mid-stream:** assert rst_ni low after 1 of 4 beats. Required: all outputs return to their reset values in the same cycle; after release, busy_o = 0 and the next accepted op streams normally.
